// File: rtl/button_conditioner.sv
// button_conditioner: 2-FF sync and debounce for two active-low push buttons, clean one-cycle
// press pulses with simultaneous-press lockout. Define AUTOREPEAT_EN for auto-repeat while held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_btn_n,
    input  logic dec_btn_n,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_held,
    output logic dec_held,
    output logic both_pressed
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARMED_INC, ARMED_DEC, LOCK} state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       sync_meta;
    logic [1:0]       sync_out;
    logic [1:0]       stable;
    logic [1:0]       stable_d;
    logic [CNT_W-1:0] deb_cnt [2];
    logic             inc_s;
    logic             dec_s;
    logic             inc_rise;
    logic             dec_rise;
    logic             inc_fire;
    logic             dec_fire;
    logic             rep_hit;

    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
            $error("button_conditioner: illegal parameter values");
        end
    endgenerate

    // Bit 0 carries the increment button, bit 1 the decrement button (raw, active-low).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 2'b11;
            sync_out  <= 2'b11;
        end else begin
            sync_meta <= {dec_btn_n, inc_btn_n};
            sync_out  <= sync_meta;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 2'b00;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (~sync_out[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    stable[i]  <= ~stable[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign inc_s    = stable[0];
    assign dec_s    = stable[1];
    assign inc_rise = stable[0] & ~stable_d[0];
    assign dec_rise = stable[1] & ~stable_d[1];
    assign inc_held = stable[0];
    assign dec_held = stable[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            stable_d  <= 2'b00;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            stable_d  <= stable;
            inc_pulse <= inc_fire;
            dec_pulse <= dec_fire;
        end
    end

    // Seeing the other button in an armed state wins over a same-cycle release, so it is never lost.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (inc_s && dec_s)  state_next = LOCK;
                else if (inc_rise)   state_next = ARMED_INC;
                else if (dec_rise)   state_next = ARMED_DEC;
            end
            ARMED_INC: begin
                if (dec_s)           state_next = LOCK;
                else if (!inc_s)     state_next = IDLE;
            end
            ARMED_DEC: begin
                if (inc_s)           state_next = LOCK;
                else if (!dec_s)     state_next = IDLE;
            end
            LOCK: begin
                if (!inc_s && !dec_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        inc_fire     = 1'b0;
        dec_fire     = 1'b0;
        both_pressed = (state == LOCK);
        case (state)
            IDLE: begin
                inc_fire = inc_rise & ~dec_s;
                dec_fire = dec_rise & ~inc_s;
            end
            ARMED_INC: inc_fire = inc_s & ~dec_s & rep_hit;
            ARMED_DEC: dec_fire = dec_s & ~inc_s & rep_hit;
            default: ;
        endcase
    end

`ifdef AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;

    assign rep_hit = (rep_cnt == (rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1)));

    // Counts cycles since the last emitted pulse; the first gap is the longer initial delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (inc_fire || dec_fire) begin
            rep_cnt   <= '0;
            rep_first <= (state == IDLE);
        end else if (state == ARMED_INC || state == ARMED_DEC) begin
            rep_cnt   <= rep_cnt + 1'b1;
        end else begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

endmodule
